// File: rtl/multi_mode_shift_reg.sv
// Multi-mode shift register: hold, parallel load, clear, logical/arithmetic
// shifts and rotates. Shift and rotate operations run one bit per clock for
// the requested number of steps and report completion with a one-cycle done pulse.
module multi_mode_shift_reg #(
  parameter  int WORD_SIZE = 8,
  localparam int AMT_W     = $clog2(WORD_SIZE) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           mode,
  input  logic [AMT_W-1:0]     amount,
  input  logic [WORD_SIZE-1:0] Data_In,
  input  logic                 MSB_In,
  input  logic                 LSB_In,
  output logic [WORD_SIZE-1:0] Data_Out,
  output logic                 MSB_Out,
  output logic                 LSB_Out,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0] MODE_HOLD  = 3'd0;
  localparam logic [2:0] MODE_SHR   = 3'd1;
  localparam logic [2:0] MODE_SHL   = 3'd2;
  localparam logic [2:0] MODE_LOAD  = 3'd3;
  localparam logic [2:0] MODE_ROR   = 3'd4;
  localparam logic [2:0] MODE_ROL   = 3'd5;
  localparam logic [2:0] MODE_ASR   = 3'd6;
  localparam logic [2:0] MODE_CLEAR = 3'd7;

  state_t               state_q, state_d;
  logic [AMT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           mode_q, mode_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 done_q, done_d;

  // One single-bit step of a shift or rotate; serial fills come in live.
  function automatic logic [WORD_SIZE-1:0] shift_once(
    input logic [2:0]           op,
    input logic [WORD_SIZE-1:0] d,
    input logic                 msb_fill,
    input logic                 lsb_fill
  );
    logic [WORD_SIZE-1:0] result;
    result = d;
    case (op)
      MODE_SHR: result = {msb_fill, d[WORD_SIZE-1:1]};
      MODE_SHL: result = {d[WORD_SIZE-2:0], lsb_fill};
      MODE_ROR: result = {d[0], d[WORD_SIZE-1:1]};
      MODE_ROL: result = {d[WORD_SIZE-2:0], d[WORD_SIZE-1]};
      MODE_ASR: result = {d[WORD_SIZE-1], d[WORD_SIZE-1:1]};
      default:  result = d;
    endcase
    return result;
  endfunction

  // State, counter, latched mode, data and done flag; reset aborts any run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_HOLD;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: single-edge ops finish in IDLE, shifts step through RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          case (mode)
            MODE_HOLD: begin
              done_d = 1'b1;
            end
            MODE_LOAD: begin
              data_d = Data_In;
              done_d = 1'b1;
            end
            MODE_CLEAR: begin
              data_d = '0;
              done_d = 1'b1;
            end
            default: begin
              if (amount == '0) begin
                done_d = 1'b1;
              end else begin
                mode_d  = mode;
                cnt_d   = amount;
                state_d = RUN;
              end
            end
          endcase
        end
      end
      RUN: begin
        data_d = shift_once(mode_q, data_q, MSB_In, LSB_In);
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q <= AMT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Data_Out = data_q;
  assign MSB_Out  = data_q[WORD_SIZE-1];
  assign LSB_Out  = data_q[0];
  assign busy     = (state_q == RUN);
  assign done     = done_q;

endmodule

// File: tb/tb_multi_mode_shift_reg.sv
// Self-checking bench for multi_mode_shift_reg (WORD_SIZE=8): directed cases
// followed by randomized operations checked against a whole-operation model.
module tb_multi_mode_shift_reg;

  localparam int W  = 8;
  localparam int AW = $clog2(W) + 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [2:0]    mode;
  logic [AW-1:0] amount;
  logic [W-1:0]  Data_In;
  logic          MSB_In;
  logic          LSB_In;
  logic [W-1:0]  Data_Out;
  logic          MSB_Out;
  logic          LSB_Out;
  logic          busy;
  logic          done;

  int           nVectors;
  int           nMiscompares;
  logic [W-1:0] expData;

  multi_mode_shift_reg #(.WORD_SIZE(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .amount   (amount),
    .Data_In  (Data_In),
    .MSB_In   (MSB_In),
    .LSB_In   (LSB_In),
    .Data_Out (Data_Out),
    .MSB_Out  (MSB_Out),
    .LSB_Out  (LSB_Out),
    .busy     (busy),
    .done     (done)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    assert (obs === exp) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-operation result computed directly from the shift count.
  function automatic logic [W-1:0] modelOp(input logic [2:0] m, input int n,
                                           input logic [W-1:0] d, input logic [W-1:0] din,
                                           input logic msb, input logic lsb);
    logic [W-1:0]        ones;
    logic signed [W-1:0] sd;
    int                  r;
    ones = '1;
    sd   = d;
    r    = n % W;
    case (m)
      3'd0: return d;
      3'd3: return din;
      3'd7: return '0;
      3'd1: begin
        if (n >= W) return {W{msb}};
        return (d >> n) | (msb ? ~(ones >> n) : '0);
      end
      3'd2: begin
        if (n >= W) return {W{lsb}};
        return (d << n) | (lsb ? ~(ones << n) : '0);
      end
      3'd4: begin
        if (r == 0) return d;
        return (d >> r) | (d << (W - r));
      end
      3'd5: begin
        if (r == 0) return d;
        return (d << r) | (d >> (W - r));
      end
      default: begin
        sd = sd >>> ((n >= W) ? (W - 1) : n);
        return sd;
      end
    endcase
  endfunction

  // Issue one operation, follow it to its done pulse and check timing and result.
  task automatic applyStimulus(input logic [2:0] m, input int n, input logic [W-1:0] din,
                               input logic msb, input logic lsb, input bit glitch);
    int           edges;
    int           busyCycles;
    int           expBusy;
    bit           seen;
    logic [W-1:0] expNext;
    expNext = modelOp(m, n, expData, din, msb, lsb);
    expBusy = ((m inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6}) && n > 0) ? n : 0;
    start   = 1'b1;
    mode    = m;
    amount  = AW'(n);
    Data_In = din;
    MSB_In  = msb;
    LSB_In  = lsb;
    edges      = 0;
    busyCycles = 0;
    seen       = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(posedge clk);
      #1;
      edges++;
      checkOutput("busyDoneExclusive", {31'd0, busy & done}, 32'd0);
      if (edges == 1 && expBusy > 0) begin
        checkOutput("startEdgeBusy", {31'd0, busy}, 32'd1);
        checkOutput("startEdgeDataHeld", {24'd0, Data_Out}, {24'd0, expData});
      end
      if (busy) busyCycles++;
      if (done) seen = 1'b1;
      if (glitch && !done) begin
        start   = $urandom_range(0, 1) == 1;
        mode    = $urandom_range(0, 7);
        amount  = AW'($urandom_range(0, 15));
        Data_In = W'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checkOutput("doneSeen", {31'd0, seen}, 32'd1);
    checkOutput("latencyEdges", edges, expBusy + 1);
    checkOutput("busyCycles", busyCycles, expBusy);
    checkOutput("dataOut", {24'd0, Data_Out}, {24'd0, expNext});
    checkOutput("msbOut", {31'd0, MSB_Out}, {31'd0, expNext[W-1]});
    checkOutput("lsbOut", {31'd0, LSB_Out}, {31'd0, expNext[0]});
    expData = expNext;
  endtask

  // One quiet cycle: done must have dropped and the register must hold.
  task automatic idleCycle();
    @(posedge clk);
    #1;
    checkOutput("idleDone", {31'd0, done}, 32'd0);
    checkOutput("idleBusy", {31'd0, busy}, 32'd0);
    checkOutput("idleData", {24'd0, Data_Out}, {24'd0, expData});
  endtask

  // Directed sequence, randomized operations, then an asynchronous abort.
  initial begin
    logic [2:0] rm;
    nVectors     = 0;
    nMiscompares = 0;
    expData      = '0;
    rst     = 1'b0;
    start   = 1'b0;
    mode    = '0;
    amount  = '0;
    Data_In = '0;
    MSB_In  = 1'b0;
    LSB_In  = 1'b0;

    #3;
    checkOutput("resetData", {24'd0, Data_Out}, 32'd0);
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    checkOutput("resetDone", {31'd0, done}, 32'd0);
    #20;
    rst = 1'b1;

    $display("[TB] directed cases");
    applyStimulus(3'd3, 0, 8'hA5, 1'b0, 1'b0, 1'b0);
    checkOutput("loadA5", {24'd0, Data_Out}, 32'hA5);
    idleCycle();

    applyStimulus(3'd3, 0, 8'h81, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd4, 3, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("ror3", {24'd0, Data_Out}, 32'h30);
    idleCycle();

    applyStimulus(3'd3, 0, 8'h90, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd6, 2, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("asr2", {24'd0, Data_Out}, 32'hE4);
    applyStimulus(3'd3, 0, 8'h90, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd1, 2, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("lsr2", {24'd0, Data_Out}, 32'h24);

    applyStimulus(3'd3, 0, 8'h01, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd2, 9, 8'h00, 1'b0, 1'b1, 1'b1);
    checkOutput("shl9", {24'd0, Data_Out}, 32'hFF);
    idleCycle();

    applyStimulus(3'd5, 0, 8'h00, 1'b1, 1'b1, 1'b0);
    applyStimulus(3'd3, 0, 8'h5A, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd5, 11, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd7, 0, 8'hFF, 1'b0, 1'b0, 1'b0);
    idleCycle();

    $display("[TB] randomized operations");
    for (int k = 0; k < 40; k++) begin
      rm = 3'($urandom_range(0, 7));
      applyStimulus(rm, $urandom_range(0, 15), W'($urandom), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) idleCycle();
    end

    $display("[TB] asynchronous reset during a run");
    applyStimulus(3'd3, 0, 8'hC3, 1'b0, 1'b0, 1'b0);
    start  = 1'b1;
    mode   = 3'd2;
    amount = AW'(12);
    LSB_In = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("abortRunBusy", {31'd0, busy}, 32'd1);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("abortData", {24'd0, Data_Out}, 32'd0);
    checkOutput("abortBusy", {31'd0, busy}, 32'd0);
    checkOutput("abortDone", {31'd0, done}, 32'd0);
    #3;
    rst     = 1'b1;
    expData = '0;
    for (int j = 0; j < 3; j++) idleCycle();
    applyStimulus(3'd3, 0, 8'h3C, 1'b0, 1'b0, 1'b0);
    checkOutput("loadAfterAbort", {24'd0, Data_Out}, 32'h3C);
    idleCycle();

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/multi_mode_shift_reg.md
MULTI_MODE_SHIFT_REG -- requirements
Module: multi_mode_shift_reg

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 8, meaning register width in bits (legal values >= 2).
REQ-002 The block SHALL have derived parameter AMT_W = $clog2(WORD_SIZE)+1, meaning the width of the shift-amount port.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: request an operation; sampled only in IDLE.
REQ-006 Port mode, input, 3 bits: operation select; sampled with start.
REQ-007 Port amount, input, AMT_W bits: shift count for shift/rotate modes; sampled with start.
REQ-008 Port Data_In, input, WORD_SIZE bits: parallel load data.
REQ-009 Port MSB_In, input, 1 bit: serial input for right shift.
REQ-010 Port LSB_In, input, 1 bit: serial input for left shift.
REQ-011 Port Data_Out, output, WORD_SIZE bits: register contents.
REQ-012 Ports MSB_Out and LSB_Out, output, 1 bit each: combinational copies of Data_Out[WORD_SIZE-1] and Data_Out[0].
REQ-013 Port busy, output, 1 bit: high while a multi-cycle operation is in progress.
REQ-014 Port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-015 Mode encoding SHALL be: 0 hold, 1 logical right with MSB_In fill, 2 left with LSB_In fill, 3 parallel load, 4 rotate right, 5 rotate left, 6 arithmetic right (sign bit replicated), 7 clear.
REQ-016 The FSM SHALL have two states, IDLE and RUN, plus a down-counter cnt of AMT_W bits.
REQ-017 In IDLE with start=0, Data_Out SHALL hold, busy=0, done=0.
REQ-018 For an edge k in IDLE with start=1 and mode in {0,3,7}: at edge k, Data_Out SHALL update to hold, Data_In or 0 respectively; the FSM SHALL stay in IDLE; done=1 for the single cycle after edge k; busy SHALL stay 0.
REQ-019 For an edge k in IDLE with start=1, a shift mode (1,2,4,5,6) and amount=0: Data_Out SHALL be unchanged, done=1 for one cycle after edge k, and busy SHALL stay 0.
REQ-020 For an edge k in IDLE with start=1, a shift mode and amount=N>0: at edge k, mode SHALL be latched, cnt set to N, busy set to 1, FSM moved to RUN, and Data_Out left unchanged.
REQ-021 In RUN, each edge SHALL perform exactly one 1-bit shift of the latched mode and decrement cnt; MSB_In and LSB_In SHALL be sampled live at each shift edge.
REQ-022 On the edge where cnt goes 1 -> 0: the last shift SHALL occur, busy SHALL go to 0, done SHALL be 1 for the following cycle only, and the FSM SHALL return to IDLE; total latency is N+1 edges.
REQ-023 amount SHALL NOT be clamped; N > WORD_SIZE performs N single-bit shifts, so rotates wrap and logical/arithmetic shifts saturate to the fill value.
REQ-024 start, mode and amount SHALL be ignored while busy=1; changes to mode or amount during RUN SHALL have no effect.
REQ-025 A start in the first cycle after done (FSM in IDLE) SHALL be accepted normally, giving back-to-back operation with no dead cycle.
REQ-026 done and busy SHALL never be 1 in the same cycle.

Reset
REQ-027 When rst=0, the block SHALL immediately, independent of clk, set Data_Out=0, busy=0, done=0, cnt=0, latched mode=0 and state IDLE.
REQ-028 A reset asserted during RUN SHALL abort the operation with no done pulse; the block SHALL accept start on the first rising edge after rst returns to 1.

Verification (WORD_SIZE=8)
REQ-029 Mode 3 with Data_In=8'hA5 -> Data_Out=8'hA5 after 1 edge, one done pulse, busy never high.
REQ-030 Load 8'h81, then mode 4 with amount=3 -> busy for 3 cycles, Data_Out=8'h30, done one cycle, total 4 edges.
REQ-031 Load 8'h90, then mode 6 with amount=2 -> Data_Out=8'hE4; the same sequence with mode 1 and MSB_In=0 -> Data_Out=8'h24.
REQ-032 Load 8'h01, then mode 2 with amount=9 and LSB_In=1 -> Data_Out=8'hFF after 10 edges; a start pulse with a different mode mid-run is ignored.
REQ-033 Shift mode with amount=0 -> done after 1 edge, Data_Out unchanged; back-to-back start after done is accepted.
REQ-034 rst=0 mid-RUN, asynchronous to clk -> Data_Out=0 and busy=0 immediately, no done pulse; a subsequent load works.
